// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride detector: configuration, FSM states, widths.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg
    } bp_params_e;

    typedef enum logic [2:0] {
        e_sd_idle,
        e_sd_train,
        e_sd_discover,
        e_sd_wait_iter,
        e_sd_issue
    } bp_be_stride_state_e;

    localparam int sd_conf_width_gp = 4;

    function automatic int bp_vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_detector_if.sv
// Load-training, loop-discovery, iteration-estimate and prefetch signals of the stride detector.
// master = the detector (discovery initiator), slave = its surroundings.
interface bp_be_stride_detector_if #(
    parameter int vaddr_width_p = 39,
    parameter int iter_width_p  = 8
);
    logic                     ld_v_i;
    logic [vaddr_width_p-1:0] ld_pc_i;
    logic [vaddr_width_p-1:0] ld_vaddr_i;
    logic                     start_discovery_o;
    logic                     confirm_discovery_o;
    logic [vaddr_width_p-1:0] striding_pc_o;
    logic [iter_width_p-1:0]  remaining_iterations_i;
    logic                     iter_v_i;
    logic                     iter_yumi_o;
    logic [vaddr_width_p-1:0] pf_vaddr_o;
    logic                     pf_v_o;
    logic                     pf_ready_and_i;

    modport master (
        input  ld_v_i, ld_pc_i, ld_vaddr_i, remaining_iterations_i, iter_v_i, pf_ready_and_i,
        output start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o,
               pf_vaddr_o, pf_v_o
    );

    modport slave (
        output ld_v_i, ld_pc_i, ld_vaddr_i, remaining_iterations_i, iter_v_i, pf_ready_and_i,
        input  start_discovery_o, confirm_discovery_o, striding_pc_o, iter_yumi_o,
               pf_vaddr_o, pf_v_o
    );

endinterface

// File: rtl/bp_be_stride_pf_issuer.sv
// Prefetch address generator: loads base/stride/count, streams addresses over valid/ready, flags the last.
module bp_be_stride_pf_issuer #(
    parameter int vaddr_width_p = 39,
    parameter int cnt_width_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_i,
    input  logic [vaddr_width_p-1:0] base_i,
    input  logic [vaddr_width_p-1:0] stride_i,
    input  logic [cnt_width_p-1:0]   count_i,
    input  logic                     ready_i,
    output logic                     v_o,
    output logic [vaddr_width_p-1:0] vaddr_o,
    output logic                     done_o
);

    localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);

    logic [cnt_width_p-1:0]   cnt_q, cnt_d;
    logic [vaddr_width_p-1:0] addr_q, addr_d;
    logic [vaddr_width_p-1:0] stride_q, stride_d;
    logic                     accept;

    assign v_o     = (cnt_q != '0);
    assign vaddr_o = addr_q;
    assign accept  = v_o & ready_i;
    assign done_o  = accept & (cnt_q == cnt_one_lp);

    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load_i) begin
            cnt_d    = count_i;
            addr_d   = base_i;
            stride_d = stride_i;
        end else if (accept) begin
            cnt_d  = cnt_q - cnt_one_lp;
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Backend striding-load detector: trains on committed loads, drives loop discovery, issues prefetches.
// Optional BP_BE_STRIDE_DETECTOR_STATS_EN adds saturating prefetch/retrain counters.
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int confirm_thresh_p    = 3,
    parameter int pf_depth_p          = 8,
    parameter int timeout_p           = 256,
    parameter int iter_width_p        = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bp_be_stride_detector_if.master     io
`ifdef BP_BE_STRIDE_DETECTOR_STATS_EN
    ,
    output logic [31:0]                 pf_issued_o,
    output logic [15:0]                 retrain_o
`endif
);

    localparam int vaddr_width_p  = bp_vaddr_width(bp_params_p);
    localparam int cnt_width_lp   = $clog2(pf_depth_p + 1);
    localparam int timer_width_lp = $clog2(timeout_p + 1);

    localparam logic [sd_conf_width_gp-1:0] conf_thresh_lp = sd_conf_width_gp'(confirm_thresh_p);
    localparam logic [timer_width_lp-1:0]   timer_last_lp  = timer_width_lp'(timeout_p - 1);

    bp_be_stride_state_e state_q, state_d;
    logic [vaddr_width_p-1:0]    pc_q, pc_d;
    logic [vaddr_width_p-1:0]    last_addr_q, last_addr_d;
    logic [vaddr_width_p-1:0]    stride_q, stride_d;
    logic [sd_conf_width_gp-1:0] conf_q, conf_d;
    logic [timer_width_lp-1:0]   timer_q, timer_d;
    logic                        start_q, start_d;
    logic                        confirm_q, confirm_d;

    logic                        hit;
    logic [vaddr_width_p-1:0]    stride_n;
    logic                        stride_match;
    logic [sd_conf_width_gp-1:0] conf_inc;
    logic                        iter_hs;
    logic [cnt_width_lp-1:0]     pf_cnt_n;
    logic                        pf_load;
    logic                        pf_v;
    logic                        pf_done;
    logic [vaddr_width_p-1:0]    pf_vaddr;

    assign hit          = io.ld_v_i & (io.ld_pc_i == pc_q);
    assign stride_n     = io.ld_vaddr_i - last_addr_q;
    assign stride_match = (stride_n == stride_q) && (stride_q != '0);
    assign conf_inc     = conf_q + 1'b1;
    assign iter_hs      = (state_q == e_sd_wait_iter) & io.iter_v_i;
    assign pf_cnt_n     = (int'(io.remaining_iterations_i) < pf_depth_p)
                        ? cnt_width_lp'(io.remaining_iterations_i)
                        : cnt_width_lp'(pf_depth_p);
    assign pf_load      = iter_hs & (pf_cnt_n != '0);

    assign io.iter_yumi_o         = iter_hs;
    assign io.start_discovery_o   = start_q;
    assign io.confirm_discovery_o = confirm_q;
    assign io.striding_pc_o       = pc_q;
    assign io.pf_v_o              = pf_v;
    assign io.pf_vaddr_o          = pf_vaddr;

    bp_be_stride_pf_issuer #(
        .vaddr_width_p(vaddr_width_p),
        .cnt_width_p  (cnt_width_lp)
    ) issuer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (pf_load),
        .base_i  (last_addr_q + stride_q),
        .stride_i(stride_q),
        .count_i (pf_cnt_n),
        .ready_i (io.pf_ready_and_i),
        .v_o     (pf_v),
        .vaddr_o (pf_vaddr),
        .done_o  (pf_done)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_addr_d = last_addr_q;
        stride_d    = stride_q;
        conf_d      = conf_q;
        timer_d     = timer_q;
        start_d     = 1'b0;
        confirm_d   = 1'b0;
        case (state_q)
            e_sd_idle: begin
                if (io.ld_v_i) begin
                    pc_d        = io.ld_pc_i;
                    last_addr_d = io.ld_vaddr_i;
                    stride_d    = '0;
                    conf_d      = '0;
                    timer_d     = '0;
                    state_d     = e_sd_train;
                end
            end
            e_sd_train, e_sd_discover: begin
                if (hit) begin
                    last_addr_d = io.ld_vaddr_i;
                    timer_d     = '0;
                    if (stride_match) begin
                        if (state_q == e_sd_train) begin
                            conf_d  = sd_conf_width_gp'(1);
                            start_d = 1'b1;
                            state_d = e_sd_discover;
                        end else begin
                            conf_d = conf_inc;
                            if (conf_inc == conf_thresh_lp) begin
                                confirm_d = 1'b1;
                                state_d   = e_sd_wait_iter;
                            end
                        end
                    end else begin
                        stride_d = stride_n;
                        conf_d   = '0;
                        state_d  = e_sd_train;
                    end
                end else if (timer_q == timer_last_lp) begin
                    state_d = e_sd_idle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            e_sd_wait_iter: begin
                if (io.iter_v_i) begin
                    if (pf_cnt_n == '0) begin
                        conf_d  = '0;
                        timer_d = '0;
                        state_d = e_sd_train;
                    end else begin
                        state_d = e_sd_issue;
                    end
                end
            end
            e_sd_issue: begin
                if (pf_done) begin
                    conf_d  = '0;
                    timer_d = '0;
                    state_d = e_sd_train;
                end
            end
            default: state_d = e_sd_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_sd_idle;
            pc_q        <= '0;
            last_addr_q <= '0;
            stride_q    <= '0;
            conf_q      <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            confirm_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            last_addr_q <= last_addr_d;
            stride_q    <= stride_d;
            conf_q      <= conf_d;
            timer_q     <= timer_d;
            start_q     <= start_d;
            confirm_q   <= confirm_d;
        end
    end

`ifdef BP_BE_STRIDE_DETECTOR_STATS_EN
    logic [31:0] pf_issued_q;
    logic [15:0] retrain_q;
    logic        retrain_evt;

    assign retrain_evt = (state_q == e_sd_discover) & hit & ~stride_match;
    assign pf_issued_o = pf_issued_q;
    assign retrain_o   = retrain_q;

    // Both counters stick at all-ones rather than wrapping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pf_issued_q <= '0;
            retrain_q   <= '0;
        end else begin
            if (pf_v & io.pf_ready_and_i & (pf_issued_q != '1))
                pf_issued_q <= pf_issued_q + 1'b1;
            if (retrain_evt & (retrain_q != '1))
                retrain_q <= retrain_q + 1'b1;
        end
    end
`endif

endmodule
